// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pulls words from the async FIFO read port without
// ever reading while empty, absorbs the one-cycle read latency in a 2-entry
// skid buffer, and presents the words as a valid/ready stream.
module fifo_rd_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic             flush,
  input  logic             clr_count,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       occ;
  logic [1:0]       occ_next;
  logic [1:0]       occ_after_pop;
  logic             inflight;
  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic [WIDTH-1:0] entry0_next;
  logic [WIDTH-1:0] entry1_next;
  logic             pop;
  logic             arrive;
  logic [1:0]       pending;

  assign m_valid = (occ != 2'd0);
  assign m_data  = entry0;
  assign pop     = m_valid & m_ready;
  assign arrive  = inflight & ~flush;

  // occ + inflight never exceeds 2 and pop implies occ >= 1, so 2 bits hold
  // the result without wrap.
  assign pending = occ + {1'b0, inflight} - {1'b0, pop};

  // Only issue when the word can land in a slot that is guaranteed free.
  assign fifo_rd_en = ~rst & ~fifo_empty & ~flush & (pending < 2'd2);

  // Skid buffer next state: shift on pop, then place the arriving word in the
  // first free entry; flush empties the buffer and drops the in-flight word.
  always_comb begin
    entry0_next   = entry0;
    entry1_next   = entry1;
    occ_after_pop = occ - {1'b0, pop};
    if (pop) begin
      entry0_next = entry1;
    end
    if (arrive) begin
      if (occ_after_pop == 2'd0) begin
        entry0_next = fifo_rd_data;
      end else begin
        entry1_next = fifo_rd_data;
      end
    end
    occ_next = flush ? 2'd0 : (occ_after_pop + {1'b0, arrive});
  end

  // Skid buffer and in-flight tracking registers.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      entry0   <= '0;
      entry1   <= '0;
    end else begin
      occ      <= occ_next;
      inflight <= fifo_rd_en;
      entry0   <= entry0_next;
      entry1   <= entry1_next;
    end
  end

  // Delivered-word counter; saturates, and a clear coinciding with a pop
  // still counts that pop.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
    end else if (clr_count) begin
      word_count <= pop ? CNT_ONE : '0;
    end else if (pop && (word_count != CNT_MAX)) begin
      word_count <= word_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a behavioural FIFO feeds the engine, a monitor
// records accepted beats, and each test compares them with the word order
// pushed into the FIFO.
module tb_fifo_rd_stream;

  localparam int WIDTH = 8;

  logic             rd_clk    = 1'b0;
  logic             rst       = 1'b0;
  logic             flush     = 1'b0;
  logic             clr_count = 1'b0;
  logic             m_ready   = 1'b0;
  logic             gap       = 1'b1;
  logic [WIDTH-1:0] fifo_rd_data = '0;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic             fifo_rd_en4;
  logic             m_valid;
  logic             m_valid4;
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] m_data4;
  logic [15:0]      word_count;
  logic [3:0]       word_count4;

  logic [WIDTH-1:0] mem [0:4095];
  int rd_ptr = 0;
  int wr_ptr = 0;

  int total = 0;
  int bad   = 0;
  int cyc = 0, underflow = 0, rd_cnt = 0, first_rd = -1, first_valid = -1, stab_err = 0;
  logic             hold_q = 1'b0;
  logic [WIDTH-1:0] held_q = '0;
  logic [WIDTH-1:0] got[$];
  logic [WIDTH-1:0] exp_q[$];
  int               got_cyc[$];

  assign fifo_empty = gap || (rd_ptr == wr_ptr);

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(16)) dut (
    .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .flush(flush), .clr_count(clr_count),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .word_count(word_count)
  );

  fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
    .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en4),
    .fifo_rd_data(fifo_rd_data), .flush(flush), .clr_count(clr_count),
    .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .word_count(word_count4)
  );

  // FIFO read port model plus beat/stability monitor.
  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      if (fifo_empty) underflow++;
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      fifo_rd_data <= mem[rd_ptr[11:0]];
      rd_ptr <= rd_ptr + 1;
    end
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      got_cyc.push_back(cyc);
    end
    if (!rst && hold_q && (!m_valid || m_data !== held_q)) stab_err++;
    hold_q <= m_valid & ~m_ready & ~flush & ~rst;
    held_q <= m_data;
    cyc++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    mem[wr_ptr[11:0]] = d;
    wr_ptr++;
    exp_q.push_back(d);
  endtask

  task automatic clear_obs();
    got.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    total++; if (word_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", word_count); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", m_data); end
    clear_obs();
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    m_ready = 1'b0;
    gap = 1'b0;
    step();
    rst = 1'b0;
    repeat (4) step();
    total++; if (m_valid !== 1'b1 || m_data !== 8'hA0) begin bad++; $display("FAIL mid_head: got valid=%b data=%h want 1 a0", m_valid, m_data); end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    repeat (3) step();
    total++; if (word_count !== 16'd1) begin bad++; $display("FAIL mid_count: got %0d want 1", word_count); end
    total++; if (m_valid !== 1'b1 || m_data !== 8'hA1) begin bad++; $display("FAIL mid_full: got valid=%b data=%h want 1 a1", m_valid, m_data); end
    #2 rst = 1'b1;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL async_valid: got %b want 0", m_valid); end
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL async_rd_en: got %b want 0", fifo_rd_en); end
    total++; if (word_count !== 16'd0) begin bad++; $display("FAIL async_count: got %0d want 0", word_count); end
    step();
    gap = 1'b1;
    wr_ptr = rd_ptr;
    rst = 1'b0;
    rd_cnt = 0;
    repeat (20) step();
    total++; if (rd_cnt !== 0) begin bad++; $display("FAIL idle_reads: got %0d want 0", rd_cnt); end
    clear_obs();
  endtask

  task automatic test_streaming();
    int n;
    int span;
    clear_obs();
    first_rd = -1;
    first_valid = -1;
    underflow = 0;
    for (int i = 1; i <= 16; i++) push(8'(i));
    m_ready = 1'b1;
    gap = 1'b0;
    n = 0;
    while (got.size() < 16 && n < 100) begin step(); n++; end
    total++; if (got.size() != 16) begin bad++; $display("FAIL stream_beats: got %0d want 16", got.size()); end
    total++; if (first_valid - first_rd != 2) begin bad++; $display("FAIL stream_latency: got %0d want 2", first_valid - first_rd); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL stream_data[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
    span = (got.size() == 16) ? (got_cyc[15] - got_cyc[0]) : -1;
    total++; if (span != 15) begin bad++; $display("FAIL stream_rate: span %0d want 15", span); end
    total++; if (word_count !== 16'd16) begin bad++; $display("FAIL stream_count: got %0d want 16", word_count); end
    total++; if (underflow != 0) begin bad++; $display("FAIL stream_underflow: got %0d want 0", underflow); end
    gap = 1'b1;
  endtask

  task automatic test_backpressure();
    int n;
    clear_obs();
    m_ready = 1'b0;
    rd_cnt = 0;
    stab_err = 0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    gap = 1'b0;
    repeat (10) step();
    total++; if (rd_cnt != 2) begin bad++; $display("FAIL bp_reads: got %0d want 2", rd_cnt); end
    total++; if (m_valid !== 1'b1 || m_data !== 8'h01) begin bad++; $display("FAIL bp_hold: got valid=%b data=%h want 1 01", m_valid, m_data); end
    m_ready = 1'b1;
    n = 0;
    while (got.size() < 8 && n < 100) begin step(); n++; end
    total++; if (got.size() != 8) begin bad++; $display("FAIL bp_beats: got %0d want 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
    total++; if (word_count !== 16'd24) begin bad++; $display("FAIL bp_count: got %0d want 24", word_count); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL bp_stable: got %0d violations want 0", stab_err); end
    gap = 1'b1;
  endtask

  task automatic test_random();
    int n;
    clear_obs();
    m_ready = 1'b0;
    gap = 1'b1;
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    total++; if (word_count !== 16'd0) begin bad++; $display("FAIL rnd_clear: got %0d want 0", word_count); end
    underflow = 0;
    stab_err = 0;
    for (int i = 0; i < 1000; i++) push(8'($urandom));
    n = 0;
    while (got.size() < 1000 && n < 20000) begin
      gap = ($urandom_range(0, 9) < 3);
      m_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    gap = 1'b1;
    m_ready = 1'b0;
    total++; if (got.size() != 1000) begin bad++; $display("FAIL rnd_beats: got %0d want 1000", got.size()); end
    for (int i = 0; i < got.size() && i < 1000; i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
    total++; if (word_count !== 16'd1000) begin bad++; $display("FAIL rnd_count: got %0d want 1000", word_count); end
    total++; if (underflow != 0) begin bad++; $display("FAIL rnd_underflow: got %0d want 0", underflow); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL rnd_stable: got %0d violations want 0", stab_err); end
  endtask

  task automatic test_flush();
    int n;
    repeat (3) step();
    clear_obs();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hF0 + 8'(i));
    gap = 1'b0;
    step();
    step();
    total++; if (m_valid !== 1'b1 || m_data !== 8'hF0) begin bad++; $display("FAIL fl_pre: got valid=%b data=%h want 1 f0", m_valid, m_data); end
    flush = 1'b1;
    #1;
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL fl_rd_en: got %b want 0", fifo_rd_en); end
    step();
    flush = 1'b0;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL fl_empty: got %b want 0", m_valid); end
    m_ready = 1'b1;
    n = 0;
    while (got.size() < 2 && n < 50) begin step(); n++; end
    repeat (5) step();
    total++; if (got.size() != 2) begin bad++; $display("FAIL fl_beats: got %0d want 2", got.size()); end
    if (got.size() >= 2) begin
      total++; if (got[0] !== exp_q[2]) begin bad++; $display("FAIL fl_first: got %h want %h", got[0], exp_q[2]); end
      total++; if (got[1] !== exp_q[3]) begin bad++; $display("FAIL fl_second: got %h want %h", got[1], exp_q[3]); end
    end
    gap = 1'b1;
    m_ready = 1'b0;
  endtask

  task automatic test_counter();
    int n;
    clear_obs();
    m_ready = 1'b0;
    gap = 1'b1;
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    total++; if (word_count4 !== 4'd0) begin bad++; $display("FAIL cnt_clear: got %0d want 0", word_count4); end
    for (int i = 0; i < 20; i++) push(8'h40 + 8'(i));
    m_ready = 1'b1;
    gap = 1'b0;
    n = 0;
    while (got.size() < 20 && n < 200) begin step(); n++; end
    total++; if (word_count4 !== 4'd15) begin bad++; $display("FAIL cnt_sat: got %0d want 15", word_count4); end
    total++; if (word_count !== 16'd20) begin bad++; $display("FAIL cnt_wide: got %0d want 20", word_count); end
    clear_obs();
    m_ready = 1'b0;
    push(8'h77);
    push(8'h78);
    n = 0;
    while (!m_valid && n < 20) begin step(); n++; end
    total++; if (m_valid4 !== m_valid || m_data4 !== m_data || fifo_rd_en4 !== fifo_rd_en) begin
      bad++; $display("FAIL cnt_twin: got %b %h %b want %b %h %b", m_valid4, m_data4, fifo_rd_en4, m_valid, m_data, fifo_rd_en);
    end
    m_ready = 1'b1;
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    m_ready = 1'b0;
    total++; if (word_count4 !== 4'd1) begin bad++; $display("FAIL clr_pop4: got %0d want 1", word_count4); end
    total++; if (word_count !== 16'd1) begin bad++; $display("FAIL clr_pop: got %0d want 1", word_count); end
    total++; if (got.size() != 1 || got[0] !== 8'h77) begin bad++; $display("FAIL clr_beat: got %0d beats want 1 of 77", got.size()); end
    step();
    total++; if (word_count !== 16'd1) begin bad++; $display("FAIL clr_hold: got %0d want 1", word_count); end
    gap = 1'b1;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_flush();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
